lfsr_gen: RTL and testbench

- Parametrised Fibonacci XNOR-feedback LFSR that generalises the fixed 10-flop chain.
- Configurable width and tap mask, with a serial data input mixed into the feedback and a parallel seed load.
- Adds lock-up detection with automatic recovery, plus an on-line period monitor that counts steps until the state returns to its starting value.
- Used as a stimulus and sizing generator in the benchmark benches; instances chain serially through d/q.

---
 rtl/lfsr_gen_pkg.sv | 23 ++
 rtl/lfsr_gen_if.sv | 36 +++
 rtl/lfsr_period_mon.sv | 78 +++++++
 rtl/lfsr_gen.sv | 86 ++++++++
 tb/tb_lfsr_gen.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/lfsr_gen_pkg.sv
// Shared types, tap constants and the feedback parity helper for lfsr_gen.
// The optional MISR input is enabled with the LFSR_GEN_MISR_EN macro.
package lfsr_gen_pkg;

  typedef enum logic [1:0] {
    MEASURE  = 2'd0,
    DONE     = 2'd1,
    OVERFLOW = 2'd2
  } mon_state_e;

  // Widest state the parity helper accepts; callers zero-extend into this.
  localparam int unsigned LFSR_MAX_W = 64;

  localparam logic [3:0]  TAPS_4  = 4'b1100;
  localparam logic [7:0]  TAPS_8  = 8'b10111000;
  localparam logic [15:0] TAPS_16 = 16'hB400;

  function automatic logic parity_mask(input logic [LFSR_MAX_W-1:0] state,
                                       input logic [LFSR_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle between an lfsr_gen instance and its driver.
// pdin only exists when LFSR_GEN_MISR_EN is defined.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32
);
  logic             en;
  logic             d;
  logic             load;
  logic [WIDTH-1:0] seed_in;
`ifdef LFSR_GEN_MISR_EN
  logic [WIDTH-1:0] pdin;
`endif
  logic             q;
  logic [WIDTH-1:0] state;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             overflow;
  logic             lockup;

  modport master (
`ifdef LFSR_GEN_MISR_EN
    output pdin,
`endif
    output en, d, load, seed_in,
    input  q, state, period, period_valid, overflow, lockup
  );

  modport slave (
`ifdef LFSR_GEN_MISR_EN
    input  pdin,
`endif
    input  en, d, load, seed_in,
    output q, state, period, period_valid, overflow, lockup
  );
endinterface

// File: rtl/lfsr_period_mon.sv
// Period monitor: counts LFSR steps until the state returns to its reference.
// MEASURE = counting, DONE = period captured, OVERFLOW = counter saturated first.
module lfsr_period_mon
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int unsigned      CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             restart,
  input  logic [WIDTH-1:0] restart_ref,
  input  logic [WIDTH-1:0] next_state,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_e       r_mon;
  logic [WIDTH-1:0] r_ref;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_overflow;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon      <= MEASURE;
      r_ref      <= SEED;
      r_cnt      <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (restart) begin
      r_mon      <= MEASURE;
      r_ref      <= restart_ref;
      r_cnt      <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (step) begin
      case (r_mon)
        MEASURE: begin
          r_cnt <= w_cnt_inc;
          if (next_state == r_ref) begin
            r_period <= w_cnt_inc;
            r_valid  <= 1'b1;
            r_mon    <= DONE;
          end else if (w_cnt_inc == CNT_MAX) begin
            // The all-ones count is reserved as the saturation marker.
            r_period   <= CNT_MAX;
            r_overflow <= 1'b1;
            r_mon      <= OVERFLOW;
          end
        end
        DONE, OVERFLOW: begin
          r_mon <= r_mon;
        end
        default: begin
          r_mon <= MEASURE;
        end
      endcase
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign overflow     = r_overflow;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci XNOR LFSR with seed load, lock-up recovery and period monitor.
// Define LFSR_GEN_MISR_EN to XOR a parallel pdin word into every step (MISR mode).
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int unsigned      CNT_W = 32
) (
  input logic        clk,
  input logic        reset,
  lfsr_gen_if.slave  bus
);

  logic [WIDTH-1:0]      r_state;
  logic                  r_lockup;
  logic [LFSR_MAX_W-1:0] w_state_ext;
  logic [LFSR_MAX_W-1:0] w_taps_ext;
  logic                  w_fb;
  logic [WIDTH-1:0]      w_shift;
  logic [WIDTH-1:0]      w_next;
  logic                  w_all_ones;
  logic                  w_recover;
  logic                  w_step;
  logic                  w_restart;
  logic [WIDTH-1:0]      w_restart_ref;

  always_comb begin
    w_state_ext             = '0;
    w_state_ext[WIDTH-1:0]  = r_state;
    w_taps_ext              = '0;
    w_taps_ext[WIDTH-1:0]   = TAPS;
  end

  assign w_fb    = ~(bus.d ^ parity_mask(w_state_ext, w_taps_ext));
  assign w_shift = {r_state[WIDTH-2:0], w_fb};

`ifdef LFSR_GEN_MISR_EN
  assign w_next = w_shift ^ bus.pdin;
`else
  assign w_next = w_shift;
`endif

  // All-ones is the XNOR lock-up state; it is judged on the pre-step state.
  assign w_all_ones    = &r_state;
  assign w_recover     = bus.en & ~bus.load & w_all_ones;
  assign w_step        = bus.en & ~bus.load & ~w_all_ones;
  assign w_restart     = bus.load | w_recover;
  assign w_restart_ref = bus.load ? bus.seed_in : SEED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SEED;
      r_lockup <= 1'b0;
    end else if (bus.load) begin
      r_state <= bus.seed_in;
    end else if (w_recover) begin
      r_state  <= SEED;
      r_lockup <= 1'b1;
    end else if (w_step) begin
      r_state <= w_next;
    end
  end

  lfsr_period_mon #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .CNT_W (CNT_W)
  ) u_mon (
    .clk          (clk),
    .reset        (reset),
    .step         (w_step),
    .restart      (w_restart),
    .restart_ref  (w_restart_ref),
    .next_state   (w_next),
    .period       (bus.period),
    .period_valid (bus.period_valid),
    .overflow     (bus.overflow)
  );

  assign bus.q      = r_state[WIDTH-1];
  assign bus.state  = r_state;
  assign bus.lockup = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 4-bit x^4 LFSR, a 32-bit and a 3-bit period counter.
// MISR checks run only when LFSR_GEN_MISR_EN is defined.
module tb_lfsr_gen;
  import lfsr_gen_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_pass;
  int   n_total;

  lfsr_gen_if #(.WIDTH(4), .CNT_W(32)) if_a ();
  lfsr_gen_if #(.WIDTH(4), .CNT_W(3))  if_b ();

  lfsr_gen #(.WIDTH(4), .TAPS(TAPS_4), .SEED(4'b0000), .CNT_W(32)) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(TAPS_4), .SEED(4'b0000), .CNT_W(3)) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        d;
    logic        load;
    logic [3:0]  seed;
    logic [3:0]  st;
    logic [31:0] per;
    logic        vld;
    logic        lck;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic d, logic load, logic [3:0] seed,
                              logic [3:0] st, logic [31:0] per, logic vld, logic lck);
    vec_t v;
    v.en = en; v.d = d; v.load = load; v.seed = seed;
    v.st = st; v.per = per; v.vld = vld; v.lck = lck;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_a(input string tag, input logic [3:0] st, input logic [31:0] per,
                       input logic vld, input logic ovf, input logic lck);
    chk({tag, ".state"},  {28'd0, if_a.state}, {28'd0, st});
    chk({tag, ".q"},      {31'd0, if_a.q}, {31'd0, st[3]});
    chk({tag, ".period"}, if_a.period, per);
    chk({tag, ".valid"},  {31'd0, if_a.period_valid}, {31'd0, vld});
    chk({tag, ".ovf"},    {31'd0, if_a.overflow}, {31'd0, ovf});
    chk({tag, ".lockup"}, {31'd0, if_a.lockup}, {31'd0, lck});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] st, input logic [2:0] per,
                       input logic vld, input logic ovf);
    chk({tag, ".state"},  {28'd0, if_b.state}, {28'd0, st});
    chk({tag, ".period"}, {29'd0, if_b.period}, {29'd0, per});
    chk({tag, ".valid"},  {31'd0, if_b.period_valid}, {31'd0, vld});
    chk({tag, ".ovf"},    {31'd0, if_b.overflow}, {31'd0, ovf});
  endtask

  task automatic step_a(input logic en, input logic d, input logic load, input logic [3:0] seed);
    if_a.en = en; if_a.d = d; if_a.load = load; if_a.seed_in = seed;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic en, input logic load, input logic [3:0] seed);
    if_b.en = en; if_b.d = 1'b0; if_b.load = load; if_b.seed_in = seed;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq [15];
    n_pass = 0;
    n_total = 0;
    seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0110, 4'b1100,
            4'b1001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};

    for (int i = 0; i < 15; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, seq[i], (i == 14) ? 32'd15 : 32'd0,
                       (i == 14), 1'b0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 4'b0001, 32'd15, 1, 0));  // DONE holds period
    tbl.push_back(mk(1, 1, 0, 4'h0, 4'b0010, 32'd15, 1, 0));  // d=1 flips fb
    tbl.push_back(mk(0, 0, 0, 4'h0, 4'b0010, 32'd15, 1, 0));  // en=0 freezes
    tbl.push_back(mk(0, 0, 1, 4'hF, 4'b1111, 32'd0,  0, 0));  // load all-ones
    tbl.push_back(mk(1, 0, 0, 4'h0, 4'b0000, 32'd0,  0, 1));  // lock-up recovery
    tbl.push_back(mk(1, 1, 0, 4'h0, 4'b0000, 32'd1,  1, 1));  // d=1 at 0000 is a fixed point
    tbl.push_back(mk(1, 0, 1, 4'h5, 4'b0101, 32'd0,  0, 1));  // load beats en
    tbl.push_back(mk(1, 0, 0, 4'h0, 4'b1010, 32'd0,  0, 1));

    rst_a = 1'b1; rst_b = 1'b1;
    if_a.en = 0; if_a.d = 0; if_a.load = 0; if_a.seed_in = '0;
    if_b.en = 0; if_b.d = 0; if_b.load = 0; if_b.seed_in = '0;
`ifdef LFSR_GEN_MISR_EN
    if_a.pdin = '0;
    if_b.pdin = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 4'b0000, 32'd0, 0, 0, 0);
    chk_b("reset_b", 4'b0000, 3'd0, 0, 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step_a(tbl[i].en, tbl[i].d, tbl[i].load, tbl[i].seed);
      chk_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].per, tbl[i].vld, 1'b0, tbl[i].lck);
    end

    // Lock-up recovery followed by a full measured period.
    step_a(0, 0, 1, 4'hF);
    step_a(1, 0, 0, 4'h0);
    chk_a("lock_rec", 4'b0000, 32'd0, 0, 0, 1);
    for (int i = 0; i < 14; i++) step_a(1, 0, 0, 4'h0);
    chk_a("lock_14", 4'b1000, 32'd0, 0, 0, 1);
    step_a(1, 0, 0, 4'h0);
    chk_a("lock_15", 4'b0000, 32'd15, 1, 0, 1);

    // Saturating 3-bit counter.
    for (int i = 0; i < 6; i++) step_b(1, 0, 4'h0);
    chk_b("ovf_6", 4'b1011, 3'd0, 0, 0);
    step_b(1, 0, 4'h0);
    chk_b("ovf_7", 4'b0110, 3'b111, 0, 1);
    for (int i = 0; i < 8; i++) step_b(1, 0, 4'h0);
    chk_b("ovf_15", 4'b0000, 3'b111, 0, 1);
    step_b(0, 1, 4'h0);
    chk_b("ovf_clr", 4'b0000, 3'd0, 0, 0);
    if_b.load = 1'b0;

    // Asynchronous reset in the middle of a measurement.
    step_a(0, 0, 1, 4'h0);
    step_a(1, 0, 0, 4'h0);
    step_a(1, 0, 0, 4'h0);
    chk_a("pre_rst", 4'b0011, 32'd0, 0, 0, 1);
    #3;
    rst_a = 1'b1;
    #1;
    chk_a("async_rst", 4'b0000, 32'd0, 0, 0, 0);
    @(negedge clk);
    rst_a = 1'b0;
    step_a(1, 0, 0, 4'h0);
    chk_a("rst_s1", 4'b0001, 32'd0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step_a(1, 0, 0, 4'h0);
    chk_a("rst_s15", 4'b0000, 32'd15, 1, 0, 0);

`ifdef LFSR_GEN_MISR_EN
    step_a(0, 0, 1, 4'h0);
    if_a.pdin = 4'b0001;
    step_a(1, 0, 0, 4'h0);
    chk({"misr_in", ".state"}, {28'd0, if_a.state}, 32'h0);
    if_a.pdin = 4'b0000;
    step_a(1, 0, 0, 4'h0);
    chk({"misr_s1", ".state"}, {28'd0, if_a.state}, 32'h1);
    step_a(1, 0, 0, 4'h0);
    chk({"misr_s2", ".state"}, {28'd0, if_a.state}, 32'h3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
